spi_master_cfg: RTL and testbench
=================================

// Module: spi_master_cfg
// PURPOSE
//  Full-duplex, parameterised SPI master: next generation of the single-slave, LSB-first, write-only SPI master.
//  Adds a programmable clock divider, all four CPOL/CPHA modes, selectable bit order,
//  MISO capture and NUM_CS chip selects.
//  Driven from a valid/ready request interface. Returns received data on a one-cycle rx_valid pulse.
//  All logic runs on clk. sclk is a registered output, never used as a clock.
// PARAMETERS
//  DATA_WIDTH  12  bits per transfer (>=2)
//  CLK_DIV     5   clk cycles per sclk half-period (>=1)
//  NUM_CS      2   number of active-low chip selects (>=1)
//  CS_W        $clog2(NUM_CS) (min 1)  width of tx_cs_sel (localparam)
// PORTS
//  clk        in   1           system clock
//  reset      in   1           synchronous, active-high reset
//  tx_valid   in   1           request valid
//  tx_ready   out  1           block idle, request accepted when tx_valid&&tx_ready
//  tx_data    in   DATA_WIDTH  word to shift out
//  tx_cs_sel  in   CS_W        index of slave to select
//  cpol       in   1           sclk idle level, sampled at acceptance
//  cpha       in   1           0: sample leading edge / 1: sample trailing edge, sampled at acceptance
//  lsb_first  in   1           1: bit 0 first / 0: MSB first, sampled at acceptance
//  rx_valid   out  1           one-cycle pulse, rx_data valid
//  rx_data    out  DATA_WIDTH  word captured from miso, held until next rx_valid
//  busy       out  1           transfer in progress (= !tx_ready)
//  sclk       out  1           SPI clock
//  mosi       out  1           master out
//  miso       in   1           master in, assumed stable around sampling edge
//  cs_n       out  NUM_CS      active-low selects, at most one low
// BEHAVIOUR
//  Reset values: sclk=0, mosi=0, cs_n=all 1, tx_ready=1, busy=0, rx_valid=0, rx_data=0.
//  Reset asserted mid-transfer aborts it the next edge: no rx_valid, cs_n all high.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//  IDLE:
//   - tx_ready=1; sclk follows the latched cpol, which is 0 after reset.
//   - On accept at cycle 0: latch data, cs_sel and mode. Go to SETUP.
//  SETUP: cycles 1..CLK_DIV.
//   - cs_n[sel] low, sclk=cpol.
//   - cpha=0: first bit already on mosi at entry.
//  XFER: 2*DATA_WIDTH half-periods of CLK_DIV cycles each.
//   - sclk toggles at each half-period end.
//   - Edges alternate leading/trailing.
//   - cpha=0: sample miso on leading edge; drive next bit on trailing edge.
//   - cpha=1: drive bit on leading edge; sample on trailing edge.
//   - Bit-order rules:
//     - lsb_first selects shift direction for both mosi and rx assembly.
//     - The first received bit lands in bit 0 (lsb_first=1) or bit DATA_WIDTH-1 (lsb_first=0).
//   - The last edge leaves sclk=cpol.
//  HOLD: CLK_DIV cycles; cs_n still low, sclk=cpol.
//  Exit: next cycle:
//   - cs_n all high, mosi=0, tx_ready=1, busy=0.
//   - rx_valid=1 with rx_data.
//  Latency: accept -> rx_valid = CLK_DIV*(2*DATA_WIDTH+2)+1 cycles.
//  Back-to-back:
//   - tx_valid high in the rx_valid cycle is accepted there.
//   - cs_n is then high for exactly 1 cycle between frames.
//  tx_valid while busy: ignored; inputs not sampled.
//  tx_cs_sel >= NUM_CS:
//   - Transfer runs normally with no cs_n asserted.
//   - rx_valid still pulses; rx_data = captured miso.
//  Counters: divider 0..CLK_DIV-1 wraps; edge counter 0..2*DATA_WIDTH-1, no overflow past that.
// TESTING (DATA_WIDTH=8, CLK_DIV=2, NUM_CS=2, miso looped to mosi unless noted)
//  1. Mode 0, MSB first, tx 0xA5, sel 0:
//     - 8 rising edges; cs_n=2'b10 during frame.
//     - rx_valid 37 cycles after accept; rx_data=0xA5.
//  2. Mode 3, LSB first, tx 0x3C, sel 1:
//     - sclk idles high; mosi bit order 0,0,1,1,1,1,0,0.
//     - cs_n=2'b01; rx_data=0x3C.
//  3. Modes 1 and 2, miso tied 1, tx 0x00:
//     - rx_data=0xFF; sampling on the trailing edge (mode 1) / leading edge (mode 2) per cpha.
//  4. tx_valid held high, two words 0x11 then 0xEE:
//     - second accept in the first rx_valid cycle; cs_n high 1 cycle.
//     - rx 0x11 then 0xEE.
//  5. Reset after 4 sclk edges:
//     - all outputs return to reset values next cycle; no rx_valid.
//     - A new transfer then completes correctly.
//  6. tx_cs_sel=1 with NUM_CS=1:
//     - cs_n stays 1 throughout; rx_valid still pulses at 37 cycles.

Source files
------------

// File: rtl/spi_master_cfg_if.sv
// -----------------------------------------------------------------------------
// spi_master_cfg_if
// Request/response bundle between a requester and the spi_master_cfg block.
//   tx_valid/tx_ready   : request handshake, accepted when both are high
//   tx_data, tx_cs_sel  : word to send and index of the slave to select
//   cpol/cpha/lsb_first : per-transfer SPI mode and bit order
//   rx_valid/rx_data    : one-cycle completion pulse with the received word
//   busy                : transfer in progress (inverse of tx_ready)
// Modports: master = requester side, slave = SPI block side.
// -----------------------------------------------------------------------------
interface spi_master_cfg_if #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_CS     = 2
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] tx_data;
   logic [CS_W-1:0]       tx_cs_sel;
   logic                  cpol;
   logic                  cpha;
   logic                  lsb_first;
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  busy;

   modport master (
      output tx_valid, tx_data, tx_cs_sel, cpol, cpha, lsb_first,
      input  tx_ready, rx_valid, rx_data, busy
   );

   modport slave (
      input  tx_valid, tx_data, tx_cs_sel, cpol, cpha, lsb_first,
      output tx_ready, rx_valid, rx_data, busy
   );
endinterface

// File: rtl/spi_master_cfg.sv
// -----------------------------------------------------------------------------
// spi_master_cfg
// Full-duplex SPI master with programmable divider, all four CPOL/CPHA modes,
// selectable bit order, MISO capture and NUM_CS active-low chip selects.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_master_cfg_if.slave request/response bundle
//   o_sclk     : SPI clock (registered, never used as a clock internally)
//   o_mosi     : master out
//   o_cs_n     : active-low chip selects, at most one low
//   i_miso     : master in
// Frame: IDLE -> SETUP (CLK_DIV) -> XFER (2*DATA_WIDTH half-periods of
// CLK_DIV) -> HOLD (CLK_DIV) -> IDLE with a one-cycle rx_valid pulse.
// -----------------------------------------------------------------------------
module spi_master_cfg #(
   parameter int DATA_WIDTH = 12,
   parameter int CLK_DIV    = 5,
   parameter int NUM_CS     = 2
) (
   input  logic              clk,
   input  logic              reset,
   spi_master_cfg_if.slave   bus,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic [NUM_CS-1:0] o_cs_n,
   input  logic              i_miso
);
   localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]            r_state;
   logic [DIV_W-1:0]      r_div;
   logic [EDGE_W-1:0]     r_edge;
   logic [DATA_WIDTH-1:0] r_tx_sh;
   logic [DATA_WIDTH-1:0] r_rx_sh;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic [NUM_CS-1:0]     r_cs_n;
   logic                  r_cpol;
   logic                  r_cpha;
   logic                  r_lsb;
   logic                  r_sclk;
   logic                  r_mosi;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_rx_valid;

   logic                  w_div_end;
   logic                  w_leading;
   logic                  w_sample_edge;
   logic                  w_drive_edge;

   // Out-of-range selects decode to no chip select at all.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] v;
      for (int i = 0; i < NUM_CS; i++) begin
         v[i] = (int'(sel) == i) ? 1'b0 : 1'b1;
      end
      return v;
   endfunction

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] sh, input logic lsb);
      return lsb ? sh[0] : sh[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] sh,
                                                      input logic lsb);
      return lsb ? {1'b0, sh[DATA_WIDTH-1:1]} : {sh[DATA_WIDTH-2:0], 1'b0};
   endfunction

   // LSB-first fills from the top so the first bit ends in bit 0; MSB-first the reverse.
   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sh,
                                                     input logic b, input logic lsb);
      return lsb ? {b, sh[DATA_WIDTH-1:1]} : {sh[DATA_WIDTH-2:0], b};
   endfunction

   // Even edge indices are leading edges (away from cpol), odd ones trailing.
   assign w_div_end     = (r_div == DIV_LAST);
   assign w_leading     = ~r_edge[0];
   assign w_sample_edge = r_cpha ? ~w_leading : w_leading;
   // With cpha=0 the first bit is already out, so the final trailing edge drives nothing.
   assign w_drive_edge  = r_cpha ? w_leading : (~w_leading && (r_edge != EDGE_LAST));

   // Frame sequencer, shift registers and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_div      <= {DIV_W{1'b0}};
         r_edge     <= {EDGE_W{1'b0}};
         r_tx_sh    <= {DATA_WIDTH{1'b0}};
         r_rx_sh    <= {DATA_WIDTH{1'b0}};
         r_rx_data  <= {DATA_WIDTH{1'b0}};
         r_cs_n     <= {NUM_CS{1'b1}};
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_lsb      <= 1'b0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sclk <= r_cpol;
               if (bus.tx_valid) begin
                  r_state <= S_SETUP;
                  r_div   <= {DIV_W{1'b0}};
                  r_edge  <= {EDGE_W{1'b0}};
                  r_cpol  <= bus.cpol;
                  r_cpha  <= bus.cpha;
                  r_lsb   <= bus.lsb_first;
                  r_sclk  <= bus.cpol;
                  r_cs_n  <= cs_decode(bus.tx_cs_sel);
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_rx_sh <= {DATA_WIDTH{1'b0}};
                  if (bus.cpha) begin
                     r_mosi  <= 1'b0;
                     r_tx_sh <= bus.tx_data;
                  end else begin
                     r_mosi  <= first_bit(bus.tx_data, bus.lsb_first);
                     r_tx_sh <= shift_out(bus.tx_data, bus.lsb_first);
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_SETUP: begin
               if (w_div_end) begin
                  r_div   <= {DIV_W{1'b0}};
                  r_state <= S_XFER;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            S_XFER: begin
               if (w_div_end) begin
                  r_div  <= {DIV_W{1'b0}};
                  r_sclk <= ~r_sclk;
                  if (w_sample_edge) begin
                     r_rx_sh <= shift_in(r_rx_sh, i_miso, r_lsb);
                  end else begin
                     r_rx_sh <= r_rx_sh;
                  end
                  if (w_drive_edge) begin
                     r_mosi  <= first_bit(r_tx_sh, r_lsb);
                     r_tx_sh <= shift_out(r_tx_sh, r_lsb);
                  end else begin
                     r_tx_sh <= r_tx_sh;
                  end
                  if (r_edge == EDGE_LAST) begin
                     r_edge  <= {EDGE_W{1'b0}};
                     r_state <= S_HOLD;
                  end else begin
                     r_edge <= r_edge + EDGE_W'(1);
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            S_HOLD: begin
               if (w_div_end) begin
                  r_div      <= {DIV_W{1'b0}};
                  r_state    <= S_IDLE;
                  r_cs_n     <= {NUM_CS{1'b1}};
                  r_mosi     <= 1'b0;
                  r_ready    <= 1'b1;
                  r_busy     <= 1'b0;
                  r_rx_valid <= 1'b1;
                  r_rx_data  <= r_rx_sh;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cs_n  <= {NUM_CS{1'b1}};
               r_mosi  <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_ready = r_ready;
   assign bus.busy     = r_busy;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_data  = r_rx_data;
   assign o_sclk       = r_sclk;
   assign o_mosi       = r_mosi;
   assign o_cs_n       = r_cs_n;
endmodule

// File: tb/tb_spi_master_cfg.sv
// -----------------------------------------------------------------------------
// tb_spi_master_cfg
// Directed bench for spi_master_cfg (DATA_WIDTH=8, CLK_DIV=2). A second
// instance with NUM_CS=1 runs in parallel on the same requests to cover an
// out-of-range chip select. MISO is looped back to MOSI unless tie1 is set.
// -----------------------------------------------------------------------------
module tb_spi_master_cfg;
   localparam int DW  = 8;
   localparam int DIV = 2;
   localparam int LAT = DIV * (2 * DW + 2) + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_cs_sel = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       lsb_first = 1'b0;
   logic       tie1 = 1'b0;

   logic       sclk1, mosi1, miso1;
   logic [1:0] cs_n1;
   logic       sclk2, mosi2, miso2;
   logic [0:0] cs_n2;

   int checks = 0;
   int errors = 0;

   // Results of the most recent frame.
   int         lat, lat2, rises, cs_bad, cs2_low;
   logic [7:0] rxd, rxd2, seq;
   logic [1:0] cs_rx;
   logic       mosi_rx, sclk_rx, sclk_k1, busy_k1;

   always #5 clk = ~clk;

   spi_master_cfg_if #(.DATA_WIDTH(DW), .NUM_CS(2)) u_if ();
   spi_master_cfg_if #(.DATA_WIDTH(DW), .NUM_CS(1)) u_if2 ();

   assign u_if.tx_valid   = tx_valid;
   assign u_if.tx_data    = tx_data;
   assign u_if.tx_cs_sel  = tx_cs_sel;
   assign u_if.cpol       = cpol;
   assign u_if.cpha       = cpha;
   assign u_if.lsb_first  = lsb_first;
   assign u_if2.tx_valid  = tx_valid;
   assign u_if2.tx_data   = tx_data;
   assign u_if2.tx_cs_sel = tx_cs_sel;
   assign u_if2.cpol      = cpol;
   assign u_if2.cpha      = cpha;
   assign u_if2.lsb_first = lsb_first;

   assign miso1 = tie1 ? 1'b1 : mosi1;
   assign miso2 = tie1 ? 1'b1 : mosi2;

   spi_master_cfg #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .NUM_CS(2)) u_dut (
      .clk(clk), .reset(reset), .bus(u_if),
      .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs_n1), .i_miso(miso1)
   );

   spi_master_cfg #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .NUM_CS(1)) u_dut2 (
      .clk(clk), .reset(reset), .bus(u_if2),
      .o_sclk(sclk2), .o_mosi(mosi2), .o_cs_n(cs_n2), .i_miso(miso2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_sclk"},     32'(sclk1), 32'h0);
      chk({pfx, "_mosi"},     32'(mosi1), 32'h0);
      chk({pfx, "_cs_n"},     32'(cs_n1), 32'h3);
      chk({pfx, "_ready"},    32'(u_if.tx_ready), 32'h1);
      chk({pfx, "_busy"},     32'(u_if.busy), 32'h0);
      chk({pfx, "_rx_valid"}, 32'(u_if.rx_valid), 32'h0);
      chk({pfx, "_rx_data"},  32'(u_if.rx_data), 32'h0);
   endtask

   // Starts at a negedge, requests one frame and follows it to rx_valid.
   // seq collects mosi at each slave sampling edge, first bit in bit 7.
   task automatic run_frame(input logic [7:0] d, input logic sel, input logic cp,
                            input logic ch, input logic lsb, input logic keep);
      logic       prev;
      logic [1:0] exp_cs;
      exp_cs    = sel ? 2'b01 : 2'b10;
      tx_data   = d;
      tx_cs_sel = sel;
      cpol      = cp;
      cpha      = ch;
      lsb_first = lsb;
      tx_valid  = 1'b1;
      lat = 0; lat2 = 0; rises = 0; cs_bad = 0; cs2_low = 0;
      seq = 8'h00; rxd = 8'h00; rxd2 = 8'h00; prev = 1'b0;
      cs_rx = 2'b00; mosi_rx = 1'b1; sclk_rx = 1'b0; sclk_k1 = 1'b0; busy_k1 = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (!keep) tx_valid = 1'b0;
            sclk_k1 = sclk1;
            busy_k1 = u_if.busy;
         end
         if (cs_n2 == 1'b0) cs2_low++;
         if (u_if2.rx_valid && lat2 == 0) begin
            lat2 = k;
            rxd2 = u_if2.rx_data;
         end
         if (u_if.rx_valid) begin
            lat     = k;
            rxd     = u_if.rx_data;
            cs_rx   = cs_n1;
            mosi_rx = mosi1;
            sclk_rx = sclk1;
            break;
         end
         if (cs_n1 != exp_cs) cs_bad++;
         if (k > 1 && sclk1 != prev) begin
            if (sclk1 && !prev) rises++;
            if ((sclk1 != cp) != ch) seq = {seq[6:0], mosi1};
         end
         prev = sclk1;
      end
   endtask

   initial begin
      int edges;
      int nrx;
      logic prev;

      // Reset state
      repeat (3) @(negedge clk);
      chk_reset("rst");
      reset = 1'b0;
      @(negedge clk);

      // 1. Mode 0, MSB first, 0xA5, sel 0
      run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_latency", 32'(lat), 32'(LAT));
      chk("t1_rx_data", 32'(rxd), 32'hA5);
      chk("t1_rises",   32'(rises), 32'd8);
      chk("t1_mosi",    32'(seq), 32'hA5);
      chk("t1_cs_bad",  32'(cs_bad), 32'd0);
      chk("t1_cs_exit", 32'(cs_rx), 32'h3);
      chk("t1_mosi_ex", 32'(mosi_rx), 32'h0);
      chk("t1_busy",    32'(busy_k1), 32'h1);

      // 2. Mode 3, LSB first, 0x3C, sel 1 (bits 0,0,1,1,1,1,0,0)
      run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t2_latency", 32'(lat), 32'(LAT));
      chk("t2_rx_data", 32'(rxd), 32'h3C);
      chk("t2_mosi",    32'(seq), 32'h3C);
      chk("t2_rises",   32'(rises), 32'd8);
      chk("t2_cs_bad",  32'(cs_bad), 32'd0);
      chk("t2_sclk_st", 32'(sclk_k1), 32'h1);
      chk("t2_sclk_ex", 32'(sclk_rx), 32'h1);

      // 3. Modes 1 and 2: miso tied high, then loopback
      tie1 = 1'b1;
      run_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_m1_tie",  32'(rxd), 32'hFF);
      chk("t3_m1_sclk", 32'(sclk_k1), 32'h0);
      run_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_m2_tie",  32'(rxd), 32'hFF);
      chk("t3_m2_sclk", 32'(sclk_k1), 32'h1);
      tie1 = 1'b0;
      run_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_m1_rx",   32'(rxd), 32'h5A);
      chk("t3_m1_mosi", 32'(seq), 32'h5A);
      run_frame(8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_m2_rx",   32'(rxd), 32'h96);
      chk("t3_m2_mosi", 32'(seq), 32'h69);
      chk("t3_m2_rise", 32'(rises), 32'd8);

      // 4. Back-to-back with tx_valid held high
      run_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_rx1",     32'(rxd), 32'h11);
      chk("t4_lat1",    32'(lat), 32'(LAT));
      chk("t4_gap_cs",  32'(cs_rx), 32'h3);
      run_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_lat2",    32'(lat), 32'(LAT));
      chk("t4_rx2",     32'(rxd), 32'hEE);
      chk("t4_cs_bad",  32'(cs_bad), 32'd0);

      // 5. Reset after 4 sclk edges, mode 3
      tx_data = 8'h5A; tx_cs_sel = 1'b0; cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b0;
      tx_valid = 1'b1;
      edges = 0;
      prev = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            tx_valid = 1'b0;
            prev = sclk1;
         end else begin
            if (sclk1 != prev) edges++;
            prev = sclk1;
         end
         if (edges == 4) break;
      end
      chk("t5_edges", 32'(edges), 32'd4);
      reset = 1'b1;
      @(negedge clk);
      chk_reset("t5_rst");
      reset = 1'b0;
      nrx = 0;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (u_if.rx_valid) nrx++;
      end
      chk("t5_no_rx", 32'(nrx), 32'd0);
      run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_latency", 32'(lat), 32'(LAT));
      chk("t5_rx_data", 32'(rxd), 32'h5A);

      // 6. sel 1 on the NUM_CS=1 instance: no chip select, normal completion
      run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_cs_low",  32'(cs2_low), 32'd0);
      chk("t6_latency", 32'(lat2), 32'(LAT));
      chk("t6_rx_data", 32'(rxd2), 32'hC3);
      chk("t6_main_rx", 32'(rxd), 32'hC3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
